// File: rtl/sparc_exu_ecl_eccfix_arb_if.sv
// Signal bundle between the ECC control logic, the W-stage writeback
// arbitration and the ECC-fix arbiter.
interface sparc_exu_ecl_eccfix_arb_if;
   logic       fix_req_m;
   logic [4:0] fix_rd_m;
   logic [2:0] fix_win_m;
   logic [1:0] fix_tid_m;
   logic       wb_wen_w;
   logic       fix_wen_w;
   logic [4:0] fix_rd_w;
   logic [2:0] fix_win_w;
   logic [1:0] fix_tid_w;
   logic [3:0] exu_ifu_ecc_stall;
   logic       exu_ifu_wb_hold;
   logic       fix_dup_err;

   modport master (
      output fix_req_m, fix_rd_m, fix_win_m, fix_tid_m, wb_wen_w,
      input  fix_wen_w, fix_rd_w, fix_win_w, fix_tid_w,
             exu_ifu_ecc_stall, exu_ifu_wb_hold, fix_dup_err
   );

   modport slave (
      input  fix_req_m, fix_rd_m, fix_win_m, fix_tid_m, wb_wen_w,
      output fix_wen_w, fix_rd_w, fix_win_w, fix_tid_w,
             exu_ifu_ecc_stall, exu_ifu_wb_hold, fix_dup_err
   );
endinterface

// File: rtl/sparc_exu_ecl_eccfix_arb.sv
// Queues one ECC-corrected IRF rewrite per thread and slips it into the IRF
// write port, forcing a writeback bubble when normal traffic starves it.
module sparc_exu_ecl_eccfix_arb #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned MAXWAIT = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   sparc_exu_ecl_eccfix_arb_if.slave        fix_if
);

   localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   CW   = $clog2(DEPTH + 1);
   localparam logic [3:0]    MAXW = 4'(MAXWAIT);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   typedef struct packed {
      logic [4:0] rd;
      logic [2:0] win;
      logic [1:0] tid;
   } fix_entry_t;

   typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

   fix_entry_t    mem [DEPTH];
   fix_entry_t    head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt;
   logic [3:0]    pending, pending_nxt;
   logic [3:0]    wait_cnt, wait_nxt;
   logic          dup_err_q;
   state_t        state, state_nxt;
   logic          enq, deq, drop, head_vld;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign head_vld = (count != '0);
   assign head     = mem[rd_ptr];
   assign deq      = head_vld & ~fix_if.wb_wen_w;
   // A thread still pending (even if it is dequeuing this cycle) cannot re-enqueue.
   assign drop     = fix_if.fix_req_m & (pending[fix_if.fix_tid_m] | (count == FULL));
   assign enq      = fix_if.fix_req_m & ~drop;

   always_comb begin
      count_nxt   = count;
      pending_nxt = pending;
      wait_nxt    = wait_cnt;
      state_nxt   = state;

      case ({enq, deq})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase

      if (deq) pending_nxt[head.tid] = 1'b0;
      if (enq) pending_nxt[fix_if.fix_tid_m] = 1'b1;

      if (!head_vld || deq)      wait_nxt = '0;
      else if (wait_cnt != MAXW) wait_nxt = wait_cnt + 1'b1;

      case (state)
         IDLE: begin
            if (enq) state_nxt = PEND;
         end
         PEND, FORCE: begin
            if (deq)                   state_nxt = (count_nxt == '0) ? IDLE : PEND;
            else if (wait_nxt == MAXW) state_nxt = FORCE;
            else                       state_nxt = PEND;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pending   <= '0;
         wait_cnt  <= '0;
         dup_err_q <= 1'b0;
         state     <= IDLE;
      end else begin
         if (enq) wr_ptr <= ptr_inc(wr_ptr);
         if (deq) rd_ptr <= ptr_inc(rd_ptr);
         count     <= count_nxt;
         pending   <= pending_nxt;
         wait_cnt  <= wait_nxt;
         dup_err_q <= drop;
         state     <= state_nxt;
      end
   end

   // Entry storage is not reset; outputs are gated by head_vld instead.
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= '{rd: fix_if.fix_rd_m, win: fix_if.fix_win_m, tid: fix_if.fix_tid_m};
   end

   assign fix_if.fix_wen_w         = deq;
   assign fix_if.fix_rd_w          = head_vld ? head.rd  : '0;
   assign fix_if.fix_win_w         = head_vld ? head.win : '0;
   assign fix_if.fix_tid_w         = head_vld ? head.tid : '0;
   assign fix_if.exu_ifu_ecc_stall = pending;
   assign fix_if.exu_ifu_wb_hold   = (state == FORCE);
   assign fix_if.fix_dup_err       = dup_err_q;

endmodule

// File: tb/tb_sparc_exu_ecl_eccfix_arb.sv
// Directed bench for the ECC-fix arbiter: each task drives one scenario and
// checks cycle-exact outputs against hand-derived values.
module tb_sparc_exu_ecl_eccfix_arb;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   sparc_exu_ecl_eccfix_arb_if fix_if();

   sparc_exu_ecl_eccfix_arb #(.DEPTH(4), .MAXWAIT(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .fix_if (fix_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Set this cycle's inputs, then let combinational outputs settle.
   task automatic drive(input logic req, input logic [4:0] rd, input logic [2:0] win,
                        input logic [1:0] tid, input logic wb);
      fix_if.fix_req_m = req;
      fix_if.fix_rd_m  = rd;
      fix_if.fix_win_m = win;
      fix_if.fix_tid_m = tid;
      fix_if.wb_wen_w  = wb;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b0);
      next_cycle();
      next_cycle();
      reset = 1'b0;
      #1;
      total++; if (fix_if.fix_wen_w !== 1'b0) begin bad++; $display("FAIL reset_wen got=%0b want=0", fix_if.fix_wen_w); end
      total++; if (fix_if.exu_ifu_ecc_stall !== 4'b0000) begin bad++; $display("FAIL reset_stall got=%b want=0000", fix_if.exu_ifu_ecc_stall); end
      total++; if (fix_if.exu_ifu_wb_hold !== 1'b0) begin bad++; $display("FAIL reset_hold got=%0b want=0", fix_if.exu_ifu_wb_hold); end
      total++; if (fix_if.fix_dup_err !== 1'b0) begin bad++; $display("FAIL reset_dup got=%0b want=0", fix_if.fix_dup_err); end
      total++; if ({fix_if.fix_rd_w, fix_if.fix_win_w, fix_if.fix_tid_w} !== 10'd0) begin bad++;
         $display("FAIL reset_head got=%h want=0", {fix_if.fix_rd_w, fix_if.fix_win_w, fix_if.fix_tid_w}); end
   endtask

   task automatic test_single();
      drive(1'b1, 5'd5, 3'd3, 2'd2, 1'b0);
      total++; if (fix_if.fix_wen_w !== 1'b0) begin bad++; $display("FAIL single_t0_wen got=%0b want=0", fix_if.fix_wen_w); end
      next_cycle();
      drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b0);
      total++; if (fix_if.fix_wen_w !== 1'b1) begin bad++; $display("FAIL single_wen got=%0b want=1", fix_if.fix_wen_w); end
      total++; if (fix_if.fix_rd_w !== 5'd5) begin bad++; $display("FAIL single_rd got=%0d want=5", fix_if.fix_rd_w); end
      total++; if (fix_if.fix_win_w !== 3'd3) begin bad++; $display("FAIL single_win got=%0d want=3", fix_if.fix_win_w); end
      total++; if (fix_if.fix_tid_w !== 2'd2) begin bad++; $display("FAIL single_tid got=%0d want=2", fix_if.fix_tid_w); end
      total++; if (fix_if.exu_ifu_ecc_stall !== 4'b0100) begin bad++; $display("FAIL single_stall got=%b want=0100", fix_if.exu_ifu_ecc_stall); end
      next_cycle();
      #1;
      total++; if (fix_if.fix_wen_w !== 1'b0) begin bad++; $display("FAIL single_after_wen got=%0b want=0", fix_if.fix_wen_w); end
      total++; if (fix_if.exu_ifu_ecc_stall !== 4'b0000) begin bad++; $display("FAIL single_after_stall got=%b want=0000", fix_if.exu_ifu_ecc_stall); end
      total++; if (fix_if.exu_ifu_wb_hold !== 1'b0) begin bad++; $display("FAIL single_after_hold got=%0b want=0", fix_if.exu_ifu_wb_hold); end
   endtask

   task automatic test_contention();
      drive(1'b1, 5'd7, 3'd1, 2'd0, 1'b1);
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b1);
         total++; if (fix_if.fix_wen_w !== 1'b0) begin bad++; $display("FAIL cont_wen[%0d] got=%0b want=0", i, fix_if.fix_wen_w); end
         total++; if (fix_if.exu_ifu_wb_hold !== 1'b0) begin bad++; $display("FAIL cont_hold[%0d] got=%0b want=0", i, fix_if.exu_ifu_wb_hold); end
         total++; if (fix_if.exu_ifu_ecc_stall !== 4'b0001) begin bad++; $display("FAIL cont_stall[%0d] got=%b want=0001", i, fix_if.exu_ifu_ecc_stall); end
         next_cycle();
      end
      drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b0);
      total++; if (fix_if.fix_wen_w !== 1'b1) begin bad++; $display("FAIL cont_write_wen got=%0b want=1", fix_if.fix_wen_w); end
      total++; if (fix_if.fix_rd_w !== 5'd7) begin bad++; $display("FAIL cont_write_rd got=%0d want=7", fix_if.fix_rd_w); end
      next_cycle();
      #1;
      total++; if (fix_if.exu_ifu_ecc_stall !== 4'b0000) begin bad++; $display("FAIL cont_after_stall got=%b want=0000", fix_if.exu_ifu_ecc_stall); end
      total++; if (fix_if.fix_wen_w !== 1'b0) begin bad++; $display("FAIL cont_after_wen got=%0b want=0", fix_if.fix_wen_w); end
   endtask

   // Request in cycle t; blocked t+1..t+4; hold visible t+5; bench drops wb at t+7.
   task automatic test_starvation();
      drive(1'b1, 5'd9, 3'd6, 2'd3, 1'b1);
      next_cycle();
      for (int i = 1; i <= 6; i++) begin
         drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b1);
         total++; if (fix_if.exu_ifu_wb_hold !== (i >= 5)) begin bad++;
            $display("FAIL starve_hold[t+%0d] got=%0b want=%0b", i, fix_if.exu_ifu_wb_hold, (i >= 5)); end
         total++; if (fix_if.fix_wen_w !== 1'b0) begin bad++; $display("FAIL starve_wen[t+%0d] got=%0b want=0", i, fix_if.fix_wen_w); end
         next_cycle();
      end
      drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b0);
      total++; if (fix_if.exu_ifu_wb_hold !== 1'b1) begin bad++; $display("FAIL starve_drop_hold got=%0b want=1", fix_if.exu_ifu_wb_hold); end
      total++; if (fix_if.fix_wen_w !== 1'b1) begin bad++; $display("FAIL starve_drop_wen got=%0b want=1", fix_if.fix_wen_w); end
      total++; if (fix_if.fix_tid_w !== 2'd3) begin bad++; $display("FAIL starve_drop_tid got=%0d want=3", fix_if.fix_tid_w); end
      next_cycle();
      #1;
      total++; if (fix_if.exu_ifu_wb_hold !== 1'b0) begin bad++; $display("FAIL starve_after_hold got=%0b want=0", fix_if.exu_ifu_wb_hold); end
      total++; if (fix_if.exu_ifu_ecc_stall !== 4'b0000) begin bad++; $display("FAIL starve_after_stall got=%b want=0000", fix_if.exu_ifu_ecc_stall); end
   endtask

   // Read pointer enters at 3 here, so this scenario wraps it.
   task automatic test_back_to_back();
      logic [3:0] exp_stall;
      logic [4:0] exp_rd;
      for (int i = 0; i <= 5; i++) begin
         if (i < 4) drive(1'b1, 5'(10 + i), 3'(i), 2'(i), 1'b0);
         else       drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b0);
         exp_stall = (i == 0 || i == 5) ? 4'b0000 : 4'(1 << (i - 1));
         exp_rd    = 5'(10 + i - 1);
         total++; if (fix_if.exu_ifu_ecc_stall !== exp_stall) begin bad++;
            $display("FAIL b2b_stall[%0d] got=%b want=%b", i, fix_if.exu_ifu_ecc_stall, exp_stall); end
         total++; if (fix_if.fix_wen_w !== (i >= 1 && i <= 4)) begin bad++;
            $display("FAIL b2b_wen[%0d] got=%0b want=%0b", i, fix_if.fix_wen_w, (i >= 1 && i <= 4)); end
         if (i >= 1 && i <= 4) begin
            total++; if (fix_if.fix_tid_w !== 2'(i - 1)) begin bad++; $display("FAIL b2b_tid[%0d] got=%0d want=%0d", i, fix_if.fix_tid_w, i - 1); end
            total++; if (fix_if.fix_rd_w !== exp_rd) begin bad++; $display("FAIL b2b_rd[%0d] got=%0d want=%0d", i, fix_if.fix_rd_w, exp_rd); end
         end
         next_cycle();
      end
   endtask

   task automatic test_duplicate();
      drive(1'b1, 5'd4, 3'd2, 2'd1, 1'b1);
      next_cycle();
      drive(1'b1, 5'd8, 3'd7, 2'd1, 1'b1);
      total++; if (fix_if.fix_dup_err !== 1'b0) begin bad++; $display("FAIL dup_t1 got=%0b want=0", fix_if.fix_dup_err); end
      total++; if (fix_if.exu_ifu_ecc_stall !== 4'b0010) begin bad++; $display("FAIL dup_stall got=%b want=0010", fix_if.exu_ifu_ecc_stall); end
      next_cycle();
      drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b1);
      total++; if (fix_if.fix_dup_err !== 1'b1) begin bad++; $display("FAIL dup_pulse got=%0b want=1", fix_if.fix_dup_err); end
      next_cycle();
      drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b1);
      total++; if (fix_if.fix_dup_err !== 1'b0) begin bad++; $display("FAIL dup_once got=%0b want=0", fix_if.fix_dup_err); end
      next_cycle();
      drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b0);
      total++; if (fix_if.fix_wen_w !== 1'b1) begin bad++; $display("FAIL dup_write_wen got=%0b want=1", fix_if.fix_wen_w); end
      total++; if (fix_if.fix_rd_w !== 5'd4) begin bad++; $display("FAIL dup_write_rd got=%0d want=4", fix_if.fix_rd_w); end
      next_cycle();
      #1;
      total++; if (fix_if.fix_wen_w !== 1'b0) begin bad++; $display("FAIL dup_count_one got=%0b want=0", fix_if.fix_wen_w); end
      total++; if (fix_if.exu_ifu_ecc_stall !== 4'b0000) begin bad++; $display("FAIL dup_after_stall got=%b want=0000", fix_if.exu_ifu_ecc_stall); end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'(20 + i), 3'(i), 2'(i), 1'b1);
         next_cycle();
      end
      drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b1);
      total++; if (fix_if.exu_ifu_ecc_stall !== 4'b0111) begin bad++; $display("FAIL mrst_pre_stall got=%b want=0111", fix_if.exu_ifu_ecc_stall); end
      next_cycle();
      reset = 1'b1;
      drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b1);
      next_cycle();
      reset = 1'b0;
      drive(1'b1, 5'd17, 3'd5, 2'd2, 1'b0);
      total++; if (fix_if.fix_wen_w !== 1'b0) begin bad++; $display("FAIL mrst_wen got=%0b want=0", fix_if.fix_wen_w); end
      total++; if (fix_if.exu_ifu_ecc_stall !== 4'b0000) begin bad++; $display("FAIL mrst_stall got=%b want=0000", fix_if.exu_ifu_ecc_stall); end
      total++; if (fix_if.exu_ifu_wb_hold !== 1'b0) begin bad++; $display("FAIL mrst_hold got=%0b want=0", fix_if.exu_ifu_wb_hold); end
      total++; if (fix_if.fix_rd_w !== 5'd0) begin bad++; $display("FAIL mrst_rd got=%0d want=0", fix_if.fix_rd_w); end
      next_cycle();
      drive(1'b0, 5'd0, 3'd0, 2'd0, 1'b0);
      total++; if (fix_if.fix_wen_w !== 1'b1) begin bad++; $display("FAIL mrst_new_wen got=%0b want=1", fix_if.fix_wen_w); end
      total++; if (fix_if.fix_rd_w !== 5'd17) begin bad++; $display("FAIL mrst_new_rd got=%0d want=17", fix_if.fix_rd_w); end
      total++; if (fix_if.fix_tid_w !== 2'd2) begin bad++; $display("FAIL mrst_new_tid got=%0d want=2", fix_if.fix_tid_w); end
      total++; if (fix_if.exu_ifu_ecc_stall !== 4'b0100) begin bad++; $display("FAIL mrst_new_stall got=%b want=0100", fix_if.exu_ifu_ecc_stall); end
      next_cycle();
      #1;
      total++; if (fix_if.exu_ifu_ecc_stall !== 4'b0000) begin bad++; $display("FAIL mrst_end_stall got=%b want=0000", fix_if.exu_ifu_ecc_stall); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      fix_if.fix_req_m = 1'b0;
      fix_if.fix_rd_m  = '0;
      fix_if.fix_win_m = '0;
      fix_if.fix_tid_m = '0;
      fix_if.wb_wen_w  = 1'b0;
      test_reset();
      test_single();
      test_contention();
      test_starvation();
      test_back_to_back();
      test_duplicate();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
